// File: rtl/relu_activator_if.sv
// Handshake bundle between the accumulator producer and the state/derivative consumers.
// The relu_activator block attaches through the slave modport.
interface relu_activator_if #(
  parameter int NP = 4,
  parameter int NC = 4,
  parameter int WF = 4
);
  localparam int WA = $clog2(NP) + WF;

  logic              iValid_AM_Accum;
  logic              oReady_AM_Accum;
  logic [NC*WA-1:0]  iData_AM_Accum;

  logic              oValid_BM_State;
  logic              iReady_BM_State;
  logic [NC*WF-1:0]  oData_BM_State;

  logic              oValid_BM_Deriv;
  logic              iReady_BM_Deriv;
  logic [NC-1:0]     oData_BM_Deriv;

  modport slave (
    input  iValid_AM_Accum, iData_AM_Accum, iReady_BM_State, iReady_BM_Deriv,
    output oReady_AM_Accum, oValid_BM_State, oData_BM_State, oValid_BM_Deriv, oData_BM_Deriv
  );

  modport master (
    output iValid_AM_Accum, iData_AM_Accum, iReady_BM_State, iReady_BM_Deriv,
    input  oReady_AM_Accum, oValid_BM_State, oData_BM_State, oValid_BM_Deriv, oData_BM_Deriv
  );
endinterface

// File: rtl/relu_activator.sv
// Per-lane saturating ReLU with derivative mask, buffered independently on the state and derivative channels.
// Defining RELU_ACTIVATOR_SATCNT_EN adds the oSatCount port: a sticky count of accepted vectors with any lane above MAX.
module relu_activator #(
  parameter int NP    = 4,
  parameter int NC    = 4,
  parameter int WF    = 4,
  parameter     BURST = "yes"
) (
  input  logic            iCLK,
  input  logic            iRST,
  relu_activator_if.slave bus
`ifdef RELU_ACTIVATOR_SATCNT_EN
  ,
  output logic [15:0]     oSatCount
`endif
);

  localparam int          WA    = $clog2(NP) + WF;
  localparam int unsigned DEPTH = (BURST == "yes") ? 2 : 1;
  localparam logic [1:0]  DEPTH_C = 2'(DEPTH);
  localparam logic signed [WA-1:0] MAX_A = WA'((1 << (WF - 1)) - 1);
  localparam logic [WF-1:0]        MAX_S = WF'((1 << (WF - 1)) - 1);

  logic signed [WA-1:0] lane_a;
  logic [NC*WF-1:0]     st_new;
  logic [NC-1:0]        dv_new;
  logic [NC-1:0]        over;

  logic                 rdy_r;
  logic                 val_s_r, val_d_r;
  logic [1:0]           cnt_s, cnt_d;
  logic [1:0]           cnt_s_n, cnt_d_n;
  logic                 accept, pop_s, pop_d;
  logic                 tail_s, tail_d;
  logic                 rdy_n;

  logic [NC*WF-1:0]     st_mem   [2];
  logic [NC*WF-1:0]     st_mem_n [2];
  logic [NC-1:0]        dv_mem   [2];
  logic [NC-1:0]        dv_mem_n [2];

  always_comb begin
    st_new = '0;
    dv_new = '0;
    over   = '0;
    lane_a = '0;
    for (int unsigned i = 0; i < NC; i++) begin
      lane_a = bus.iData_AM_Accum[i*WA +: WA];
      if (!lane_a[WA-1]) begin
        if (lane_a > MAX_A) begin
          over[i]              = 1'b1;
          st_new[i*WF +: WF]   = MAX_S;
        end else begin
          st_new[i*WF +: WF]   = lane_a[WF-1:0];
          dv_new[i]            = (lane_a != '0);
        end
      end
    end
  end

  assign accept  = bus.iValid_AM_Accum && rdy_r;
  assign pop_s   = val_s_r && bus.iReady_BM_State;
  assign pop_d   = val_d_r && bus.iReady_BM_Deriv;
  assign cnt_s_n = cnt_s + {1'b0, accept} - {1'b0, pop_s};
  assign cnt_d_n = cnt_d + {1'b0, accept} - {1'b0, pop_d};
  assign tail_s  = (cnt_s_n == 2'd2);
  assign tail_d  = (cnt_d_n == 2'd2);
  // Ready is precomputed from next-cycle occupancy so it stays a pure register output.
  assign rdy_n   = (cnt_s_n < DEPTH_C) && (cnt_d_n < DEPTH_C);

  // Head shifts out on pop, then the new vector lands at the post-update tail.
  always_comb begin
    st_mem_n = st_mem;
    dv_mem_n = dv_mem;
    if (pop_s) begin
      st_mem_n[0] = st_mem[1];
      st_mem_n[1] = '0;
    end
    if (pop_d) begin
      dv_mem_n[0] = dv_mem[1];
      dv_mem_n[1] = '0;
    end
    if (accept) begin
      st_mem_n[tail_s] = st_new;
      dv_mem_n[tail_d] = dv_new;
    end
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      rdy_r   <= 1'b0;
      val_s_r <= 1'b0;
      val_d_r <= 1'b0;
      cnt_s   <= '0;
      cnt_d   <= '0;
      st_mem  <= '{default: '0};
      dv_mem  <= '{default: '0};
    end else begin
      rdy_r   <= rdy_n;
      val_s_r <= (cnt_s_n != 2'd0);
      val_d_r <= (cnt_d_n != 2'd0);
      cnt_s   <= cnt_s_n;
      cnt_d   <= cnt_d_n;
      st_mem  <= st_mem_n;
      dv_mem  <= dv_mem_n;
    end
  end

  assign bus.oReady_AM_Accum = rdy_r;
  assign bus.oValid_BM_State = val_s_r;
  assign bus.oData_BM_State  = st_mem[0];
  assign bus.oValid_BM_Deriv = val_d_r;
  assign bus.oData_BM_Deriv  = dv_mem[0];

`ifdef RELU_ACTIVATOR_SATCNT_EN
  logic [15:0] sat_cnt;

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      sat_cnt <= '0;
    end else if (accept && (|over) && (sat_cnt != '1)) begin
      sat_cnt <= sat_cnt + 16'd1;
    end
  end

  assign oSatCount = sat_cnt;
`endif

endmodule

// File: tb/tb_relu_activator.sv
// Randomized bench for relu_activator: one BURST="yes" and one BURST="no" instance against a queue-based reference model.
module tb_relu_activator;
  localparam int NP = 4;
  localparam int NC = 4;
  localparam int WF = 4;
  localparam int WA = 6;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  relu_activator_if #(.NP(NP), .NC(NC), .WF(WF)) bus0 ();
  relu_activator_if #(.NP(NP), .NC(NC), .WF(WF)) bus1 ();

`ifdef RELU_ACTIVATOR_SATCNT_EN
  logic [15:0] sat [2];
  int          sat_m [2];
`endif

  relu_activator #(.NP(NP), .NC(NC), .WF(WF), .BURST("yes")) dut (
    .iCLK(clk), .iRST(rst), .bus(bus0)
`ifdef RELU_ACTIVATOR_SATCNT_EN
    , .oSatCount(sat[0])
`endif
  );

  relu_activator #(.NP(NP), .NC(NC), .WF(WF), .BURST("no")) dut_nb (
    .iCLK(clk), .iRST(rst), .bus(bus1)
`ifdef RELU_ACTIVATOR_SATCNT_EN
    , .oSatCount(sat[1])
`endif
  );

  logic [1:0]       vld;
  logic [NC*WA-1:0] din;
  logic             rdy_s, rdy_d;

  assign bus0.iValid_AM_Accum = vld[0];
  assign bus1.iValid_AM_Accum = vld[1];
  assign bus0.iData_AM_Accum  = din;
  assign bus1.iData_AM_Accum  = din;
  assign bus0.iReady_BM_State = rdy_s;
  assign bus1.iReady_BM_State = rdy_s;
  assign bus0.iReady_BM_Deriv = rdy_d;
  assign bus1.iReady_BM_Deriv = rdy_d;

  logic [1:0]       v_s, v_d, rdy;
  logic [NC*WF-1:0] ds [2];
  logic [NC-1:0]    dd [2];

  assign v_s = {bus1.oValid_BM_State, bus0.oValid_BM_State};
  assign v_d = {bus1.oValid_BM_Deriv, bus0.oValid_BM_Deriv};
  assign rdy = {bus1.oReady_AM_Accum, bus0.oReady_AM_Accum};
  assign ds[0] = bus0.oData_BM_State;
  assign ds[1] = bus1.oData_BM_State;
  assign dd[0] = bus0.oData_BM_Deriv;
  assign dd[1] = bus1.oData_BM_Deriv;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer evaluation of the clamp rule per lane.
  function automatic void relu_model(input logic [NC*WA-1:0] acc, output logic [NC*WF-1:0] st,
                                     output logic [NC-1:0] dv, output logic ov);
    logic signed [WA-1:0] lane;
    int a;
    st = '0;
    dv = '0;
    ov = 1'b0;
    for (int i = 0; i < NC; i++) begin
      lane = acc[i*WA +: WA];
      a = int'(lane);
      if (a < 0) begin
        st[i*WF +: WF] = 4'd0;
      end else if (a > 7) begin
        st[i*WF +: WF] = 4'd7;
        ov = 1'b1;
      end else begin
        st[i*WF +: WF] = 4'(a);
        dv[i] = (a != 0);
      end
    end
  endfunction

  logic [NC*WF-1:0] qs [2][$];
  logic [NC-1:0]    qd [2][$];
  int               depth [2] = '{2, 1};
  logic [NC*WF-1:0] m_st;
  logic [NC-1:0]    m_dv;
  logic             m_ov;

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst) begin
        chk("rst_valid_state", 32'(v_s[d]), 32'd0);
        chk("rst_valid_deriv", 32'(v_d[d]), 32'd0);
        chk("rst_ready", 32'(rdy[d]), 32'd0);
        qs[d].delete();
        qd[d].delete();
`ifdef RELU_ACTIVATOR_SATCNT_EN
        sat_m[d] = 0;
        chk("rst_sat_count", 32'(sat[d]), 32'd0);
`endif
      end else begin
        chk("ready", 32'(rdy[d]), 32'(qs[d].size() < depth[d] && qd[d].size() < depth[d]));
        chk("valid_state", 32'(v_s[d]), 32'(qs[d].size() != 0));
        chk("valid_deriv", 32'(v_d[d]), 32'(qd[d].size() != 0));
        if (qs[d].size() != 0) chk("data_state", 32'(ds[d]), 32'(qs[d][0]));
        if (qd[d].size() != 0) chk("data_deriv", 32'(dd[d]), 32'(qd[d][0]));
`ifdef RELU_ACTIVATOR_SATCNT_EN
        chk("sat_count", 32'(sat[d]), 32'(sat_m[d]));
`endif
        if (qs[d].size() != 0 && rdy_s) void'(qs[d].pop_front());
        if (qd[d].size() != 0 && rdy_d) void'(qd[d].pop_front());
        if (vld[d] && rdy[d]) begin
          relu_model(din, m_st, m_dv, m_ov);
          qs[d].push_back(m_st);
          qd[d].push_back(m_dv);
`ifdef RELU_ACTIVATOR_SATCNT_EN
          if (m_ov && sat_m[d] < 65535) sat_m[d]++;
`endif
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    vld = '0;
    rdy_s = 1'b1;
    rdy_d = 1'b1;
    repeat (6) tick();
  endtask

  // Offers v to each instance exactly once; each takes it on its own ready cycle.
  task automatic send_one(input logic [NC*WA-1:0] v);
    logic [1:0] done;
    int n;
    done = '0;
    n = 0;
    din = v;
    while (done != 2'b11 && n < 50) begin
      for (int d = 0; d < 2; d++) begin
        if (done[d]) vld[d] = 1'b0;
        else if (rdy[d]) begin
          vld[d]  = 1'b1;
          done[d] = 1'b1;
        end
      end
      tick();
      n++;
    end
    vld = '0;
    if (done != 2'b11) chk("send_timeout", 32'(done), 32'd3);
  endtask

  function automatic logic [WA-1:0] rand_lane();
    logic [WA-1:0] r;
    case ($urandom_range(0, 7))
      0: r = 6'd0;
      1: r = 6'd7;
      2: r = 6'd8;
      3: r = 6'h20;
      4: r = 6'h1F;
      5: r = 6'h3F;
      default: r = 6'($urandom);
    endcase
    return r;
  endfunction

  function automatic logic [NC*WA-1:0] rand_vec();
    logic [NC*WA-1:0] v;
    for (int i = 0; i < NC; i++) v[i*WA +: WA] = rand_lane();
    return v;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  logic [NC*WA-1:0] v28, v29, vbnd;
  logic [NC*WA-1:0] bv [4];
  logic [NC*WF-1:0] p_st;
  logic [NC-1:0]    p_dv;
  logic             p_ov;
  int               acc, idx, nb_cnt;
  logic             took;

  initial begin
    rst = 1'b0;
    vld = '0;
    din = '0;
    rdy_s = 1'b1;
    rdy_d = 1'b1;

    v28  = {6'd20, 6'd3, 6'd0, 6'h3B};
    v29  = {6'h1F, 6'h20, 6'd8, 6'd7};
    vbnd = {6'h20, 6'd8, 6'd7, 6'd0};
    relu_model(v28, p_st, p_dv, p_ov);
    chk("model_v28_state", 32'(p_st), 32'h7300);
    chk("model_v28_deriv", 32'(p_dv), 32'h4);
    relu_model(v29, p_st, p_dv, p_ov);
    chk("model_v29_state", 32'(p_st), 32'h7077);
    chk("model_v29_deriv", 32'(p_dv), 32'h1);
    relu_model(vbnd, p_st, p_dv, p_ov);
    chk("model_bnd_state", 32'(p_st), 32'h0770);
    chk("model_bnd_deriv", 32'(p_dv), 32'h2);
    chk("model_bnd_over", 32'(p_ov), 32'h1);

    repeat (3) @(negedge clk);
    #1 rst = 1'b1;
    tick();
    chk("ready_first_edge", 32'(rdy), 32'h3);
    drain();

    send_one(v28);
    @(negedge clk);
    chk("v28_valid", 32'({v_s[0], v_d[0]}), 32'h3);
    chk("v28_state", 32'(ds[0]), 32'h7300);
    chk("v28_deriv", 32'(dd[0]), 32'h4);
    tick();
    drain();

    send_one(v29);
    @(negedge clk);
    chk("v29_state", 32'(ds[0]), 32'h7077);
    chk("v29_deriv", 32'(dd[0]), 32'h1);
    tick();
    send_one(vbnd);
    @(negedge clk);
    chk("bnd_state", 32'(ds[0]), 32'h0770);
    chk("bnd_deriv", 32'(dd[0]), 32'h2);
    tick();
    drain();

    for (int i = 0; i < 4; i++) bv[i] = rand_vec();
    rdy_s = 1'b0;
    rdy_d = 1'b1;
    acc = 0;
    idx = 0;
    din = bv[0];
    vld = 2'b11;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      took = vld[0] && rdy[0];
      tick();
      if (took) begin
        acc++;
        idx++;
        if (idx < 4) din = bv[idx];
        else vld = '0;
      end
    end
    chk("burst_accepted_stalled", 32'(acc), 32'd2);
    chk("burst_ready_low", 32'(rdy[0]), 32'd0);
    rdy_s = 1'b1;
    for (int c = 0; c < 20 && acc < 4; c++) begin
      @(negedge clk);
      took = vld[0] && rdy[0];
      tick();
      if (took) begin
        acc++;
        idx++;
        if (idx < 4) din = bv[idx];
        else vld = '0;
      end
    end
    vld = '0;
    chk("burst_accepted_total", 32'(acc), 32'd4);
    drain();

    nb_cnt = 0;
    vld = 2'b11;
    din = rand_vec();
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (vld[1] && rdy[1]) nb_cnt++;
      tick();
      din = rand_vec();
    end
    vld = '0;
    chk("nb_rate_20_cycles", 32'(nb_cnt), 32'd10);
    drain();

    for (int c = 0; c < 400; c++) begin
      vld[0] = ($urandom_range(0, 3) != 0);
      vld[1] = ($urandom_range(0, 3) != 0);
      din    = rand_vec();
      rdy_s  = ($urandom_range(0, 2) != 0);
      rdy_d  = ($urandom_range(0, 2) != 0);
      tick();
    end
    drain();

    rdy_s = 1'b0;
    rdy_d = 1'b0;
    vld = 2'b11;
    repeat (4) begin
      din = rand_vec();
      tick();
    end
    vld = '0;
    chk("full_before_reset", 32'({v_s, v_d, rdy}), 32'h3C);
    rst = 1'b0;
    #1;
    chk("reset_immediate", 32'({v_s, v_d, rdy}), 32'h0);
    @(negedge clk);
    @(negedge clk);
    #1 rst = 1'b1;
    rdy_s = 1'b1;
    rdy_d = 1'b1;
    tick();
    chk("ready_after_release", 32'(rdy), 32'h3);
    chk("no_stale_after_release", 32'({v_s, v_d}), 32'h0);

`ifdef RELU_ACTIVATOR_SATCNT_EN
    for (int k = 0; k < 10; k++) begin
      logic [NC*WA-1:0] v;
      for (int i = 0; i < NC; i++) v[i*WA +: WA] = 6'(6'($urandom_range(0, 39)) - 6'd32);
      if ((k % 5) < 3) v[$urandom_range(0, 3)*WA +: WA] = 6'd8;
      send_one(v);
    end
    drain();
    chk("sat_count_dut", 32'(sat[0]), 32'd6);
    chk("sat_count_nb", 32'(sat[1]), 32'd6);
`endif

    for (int c = 0; c < 100; c++) begin
      vld   = ($urandom_range(0, 1) != 0) ? 2'b11 : 2'b00;
      din   = rand_vec();
      rdy_s = ($urandom_range(0, 3) != 0);
      rdy_d = ($urandom_range(0, 3) != 0);
      tick();
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/relu_activator.md
RELU_ACTIVATOR -- requirements
Module: relu_activator

Interface
REQ-001 SHALL have parameter NP, default 4: predecessor neuron count; accumulator width WA = $clog2(NP)+WF.
REQ-002 SHALL have parameter NC, default 4: neuron count (lanes).
REQ-003 SHALL have parameter WF, default 4: signed fixed-point state width.
REQ-004 SHALL have parameter BURST, default "yes": "yes" gives full throughput, "no" gives a single-register stage.
REQ-005 SHALL have port iCLK, input, 1: clock, rising edge.
REQ-006 SHALL have port iRST, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have port iValid_AM_Accum, input, 1: accumulator vector valid.
REQ-008 SHALL have port oReady_AM_Accum, output, 1: accumulator vector accepted.
REQ-009 SHALL have port iData_AM_Accum, input, NC*WA: signed accumulators; lane i occupies [i*WA+:WA].
REQ-010 SHALL have ports oValid_BM_State (output, 1), iReady_BM_State (input, 1) and oData_BM_State (output, NC*WF): activated state to the next layer; lane i occupies [i*WF+:WF].
REQ-011 SHALL have ports oValid_BM_Deriv (output, 1), iReady_BM_Deriv (input, 1) and oData_BM_Deriv (output, NC): derivative mask to backprop; bit i belongs to lane i.

Function
REQ-012 SHALL compute per lane, with MAX = 2^(WF-1)-1: a<0 -> state 0, deriv 0; 0<=a<=MAX -> state a[WF-1:0], deriv (a!=0); a>MAX -> state MAX, deriv 0.
REQ-013 SHALL treat a = 0 as state 0, deriv 0; a = MAX as state MAX, deriv 1; a = MAX+1 as state MAX, deriv 0; a = -2^(WA-1) as state 0, deriv 0.
REQ-014 SHALL transfer on any channel only when valid and ready are both 1 at a rising edge.
REQ-015 SHALL drive oReady_AM_Accum from registers only, with no combinational path from iValid_AM_Accum or either iReady to it.
REQ-016 SHALL accept an input vector only when both output channels have buffer space, and SHALL then write it to both channels in the same cycle.
REQ-017 SHALL make output valid exactly 1 cycle after acceptance; State and Deriv SHALL then drain independently.
REQ-018 SHALL implement BURST="yes" as a 2-entry skid buffer per channel: sustained 1 vector/cycle when both readies are high; oReady_AM_Accum falls when either channel holds 2 entries.
REQ-019 SHALL implement BURST="no" as a 1-entry register per channel: accept only when both channels are empty, giving a maximum of 1 vector per 2 cycles.
REQ-020 SHALL keep each channel's output data stable while its valid is high and its ready is low.
REQ-021 SHALL deliver every channel strictly in order, with no loss or duplication.
REQ-022 SHALL allow a simultaneous pop and push on a full channel entry in the same cycle without stalling.

Reset
REQ-023 SHALL, while iRST=0, immediately force oValid_BM_State=0, oValid_BM_Deriv=0, oReady_AM_Accum=0, all buffer data 0 and all occupancy counts 0.
REQ-024 SHALL drive oReady_AM_Accum=1 on the first rising edge after iRST returns to 1.
REQ-025 SHALL discard all buffered vectors when reset is asserted mid-operation.

Configuration
REQ-026 SHALL, with macro RELU_ACTIVATOR_SATCNT_EN defined, add output oSatCount[15:0]: +1 per accepted vector containing at least one lane with a>MAX; it SHALL stick at 16'hFFFF, reset to 0, and be registered.
REQ-027 SHALL, without RELU_ACTIVATOR_SATCNT_EN, omit the oSatCount port and counter logic; all other behaviour SHALL be identical.

Verification (NP=4, NC=4, WF=4, WA=6, MAX=7)
REQ-028 SHALL cover lanes {3:20, 2:3, 1:0, 0:-5} with readies high -> State {7,3,0,0}, Deriv 4'b0100, both valid 1 cycle after acceptance.
REQ-029 SHALL cover lanes {7, 8, -32, 31} -> State {7,7,0,7}, Deriv 4'b0001 (lane 0 = 7).
REQ-030 SHALL cover BURST="yes" with iReady_BM_State=0 and iReady_BM_Deriv=1, streaming 4 vectors -> 2 accepted, then oReady_AM_Accum=0; raise iReady_BM_State -> all 4 vectors exit in order on both channels.
REQ-031 SHALL cover BURST="no" with continuous valid and both readies 1 for 20 cycles -> exactly 10 vectors transferred.
REQ-032 SHALL cover iRST low for 1 cycle with both channels full -> valids and ready 0 at once, no stale vector after release, ready 1 on the next edge.
REQ-033 SHALL cover RELU_ACTIVATOR_SATCNT_EN with 10 vectors, 6 containing a lane of 8 and 4 with all lanes <=7 -> oSatCount=6.
